// File: rtl/binary_to_bcd_seq.sv
// Serial double-dabble binary to packed BCD converter, one input bit per clock.
// Optional leading-zero blanking output enabled by BCD_BLANK_LEADING_ZERO_EN.
module binary_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_BLANK_LEADING_ZERO_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    if (BIN_W < 1 || BIN_W > 16) begin : g_bad_width
        $error("binary_to_bcd_seq: BIN_W must be in 1..16");
    end

    if (pow10(DIGITS) <= (longint'(1) << BIN_W) - 1) begin : g_bad_digits
        $error("binary_to_bcd_seq: DIGITS too small for BIN_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [BIN_W-1:0] shreg_q;
    logic [BIN_W-1:0] shreg_d;
    logic [SW-1:0]   scratch_q;
    logic [SW-1:0]   scratch_d;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   bcd_q;
    logic            busy_q;
    logic            done_q;

    // Add-3 is per digit with no carry, so a 4-bit wrap is intended.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
        scratch_d = {adj[SW-2:0], shreg_q[BIN_W-1]};
        shreg_d   = shreg_q << 1;
    end

`ifdef BCD_BLANK_LEADING_ZERO_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_d;
    logic              zacc;

    // Digit 0 never blanks so a zero result still shows one "0".
    always_comb begin
        blank_d = '0;
        zacc    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zacc       = zacc & (scratch_d[4*i +: 4] == 4'd0);
            blank_d[i] = zacc;
        end
    end

    assign blank = blank_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
            blank_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shreg_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q   <= shreg_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        bcd_q   <= scratch_d;
`ifdef BCD_BLANK_LEADING_ZERO_EN
                        blank_q <= blank_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed-vector bench for binary_to_bcd_seq with BIN_W=8, DIGITS=3.
// Also checks blanking when BCD_BLANK_LEADING_ZERO_EN is defined.
module tb_binary_to_bcd_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    logic [2:0]  blank;
`endif

    int nvec;
    int nbad;

    binary_to_bcd_seq #(
        .BIN_W  (8),
        .DIGITS (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
`ifdef BCD_BLANK_LEADING_ZERO_EN
        ,
        .blank   (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] exp_bcd;
        logic [2:0]  exp_blank;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] model_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [2:0] model_blank(input int v);
        logic [2:0] r;
        r    = 3'b000;
        r[2] = (v < 100);
        r[1] = (v < 10);
        return r;
    endfunction

    // Start one conversion and stop in IDLE one cycle after done.
    task automatic do_conv(input logic [7:0] b, output int lat,
                           output int bcnt);
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    int lat;
    int bcnt;
    int ndone;

    initial begin
        nvec    = 0;
        nbad    = 0;
        start   = 1'b0;
        bin     = 8'd0;
        reset_n = 1'b0;

        tbl[0] = '{8'd0,   12'h000, 3'b110};
        tbl[1] = '{8'd255, 12'h255, 3'b000};
        tbl[2] = '{8'd99,  12'h099, 3'b100};
        tbl[3] = '{8'd100, 12'h100, 3'b000};
        tbl[4] = '{8'd7,   12'h007, 3'b110};
        tbl[5] = '{8'd42,  12'h042, 3'b100};
        tbl[6] = '{8'd205, 12'h205, 3'b000};
        tbl[7] = '{8'd9,   12'h009, 3'b110};
        tbl[8] = '{8'd10,  12'h010, 3'b100};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bcd", 32'(bcd), 32'h000);
`ifdef BCD_BLANK_LEADING_ZERO_EN
        chk("reset blank", 32'(blank), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_conv(tbl[i].b, lat, bcnt);
            chk("tbl latency", 32'(lat), 32'd8);
            chk("tbl busy cycles", 32'(bcnt), 32'd8);
            chk("tbl done pulse", 32'(done), 32'd0);
            chk("tbl bcd", 32'(bcd), 32'(tbl[i].exp_bcd));
`ifdef BCD_BLANK_LEADING_ZERO_EN
            chk("tbl blank", 32'(blank), 32'(tbl[i].exp_blank));
`endif
        end

        for (int v = 0; v < 256; v++) begin
            do_conv(8'(v), lat, bcnt);
            chk("sweep latency", 32'(lat), 32'd8);
            chk("sweep bcd", 32'(bcd), 32'(model_bcd(v)));
`ifdef BCD_BLANK_LEADING_ZERO_EN
            chk("sweep blank", 32'(blank), 32'(model_blank(v)));
`endif
        end

        // start held high while bin changes mid-conversion
        @(negedge clk);
        bin   = 8'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) bin = 8'd17;
            if (k == 8) begin
                chk("hold done1", 32'(done), 32'd1);
                chk("hold bcd1", 32'(bcd), 32'h200);
            end
            if (k == 9) chk("hold busy idle", 32'(busy), 32'd0);
            if (k == 10) chk("hold reaccept", 32'(busy), 32'd1);
            if (k < 18 && done) ndone++;
            if (k > 8 && k < 18) chk("hold bcd kept", 32'(bcd), 32'h200);
            if (k == 18) begin
                chk("hold done2", 32'(done), 32'd1);
                chk("hold bcd2", 32'(bcd), 32'h017);
            end
        end
        chk("hold done count", 32'(ndone), 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back: second start right after return to IDLE
        do_conv(8'd123, lat, bcnt);
        chk("b2b first", 32'(bcd), 32'h123);
        @(negedge clk);
        bin   = 8'd45;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            chk("b2b bcd held", 32'(bcd), 32'h123);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b latency", 32'(lat), 32'd8);
        chk("b2b second", 32'(bcd), 32'h045);
        @(posedge clk);
        #1;

        // reset mid-conversion
        do_conv(8'd250, lat, bcnt);
        chk("pre-reset bcd", 32'(bcd), 32'h250);
        @(negedge clk);
        bin   = 8'd77;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid busy before rst", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst bcd", 32'(bcd), 32'h000);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("no done after rst", 32'(ndone), 32'd0);
        do_conv(8'd5, lat, bcnt);
        chk("post-rst latency", 32'(lat), 32'd8);
        chk("post-rst bcd", 32'(bcd), 32'h005);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
